// File: rtl/apb_fifo_bridge.sv
// rtl/apb_fifo_bridge.sv - APB slave bridging register accesses to TX/RX async FIFOs
//
// Purpose:
//   APB writes are tagged with their register index and pushed into the TX
//   FIFO, stalling with wait states while it is full. RX FIFO words are
//   drained continuously into shadow registers that serve APB reads.
//   Optional write timeout: define APB_FIFO_BRIDGE_TIMEOUT_EN.
//
// Ports:
//   pclk, preset_n            clock, asynchronous active-low reset
//   paddr, psel, penable,
//   pwrite, pwdata            APB request
//   pready, prdata, pslverr   APB response (registered)
//   fifo_write_full           TX FIFO full
//   fifo_write_data/_inc      TX push word {tag, data} and strobe
//   fifo_read_empty/_data     RX FIFO status and head word {tag, data}
//   fifo_read_inc             RX pop strobe
//   irq_rx                    level, new data for DATA_IDX pending
//   rx_drop                   pulse, RX word with out-of-range tag discarded

module apb_fifo_bridge #(
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 4,
  parameter int                  TAG_W       = 2,
  parameter logic [15:0]         BASE_ADDR   = 16'd1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 4'b0100,
  parameter int                  DATA_IDX    = 1,
  parameter int                  TIMEOUT_CYC = 255
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic [15:0]             paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_W-1:0]       pwdata,
  output logic                    pready,
  output logic [DATA_W-1:0]       prdata,
  output logic                    pslverr,
  input  logic                    fifo_write_full,
  output logic [TAG_W+DATA_W-1:0] fifo_write_data,
  output logic                    fifo_write_inc,
  input  logic                    fifo_read_empty,
  input  logic [TAG_W+DATA_W-1:0] fifo_read_data,
  output logic                    fifo_read_inc,
  output logic                    irq_rx,
  output logic                    rx_drop
);

  // Shadow storage covers the whole tag space so any in-range tag can index
  // it directly; slots at or above NUM_REGS are never written and stay zero.
  localparam int NSLOT = 1 << TAG_W;
  localparam logic [NSLOT-1:0] RO_PAD = NSLOT'(RO_MASK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [15:0]        idx;
  logic               wr;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  shadow [NSLOT];

  logic [TAG_W-1:0]   idx_tag;
  logic               in_range;
  logic               ro_hit;
  logic               irq_clr;
  logic [TAG_W-1:0]   rx_tag;
  logic [DATA_W-1:0]  rx_data;

`ifdef APB_FIFO_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   wait_cnt;
`endif

  // Full 16-bit index is range-checked so addresses below BASE_ADDR (which
  // wrap to large values) are rejected too.
  assign idx_tag  = idx[TAG_W-1:0];
  assign in_range = (32'(idx) < NUM_REGS);
  assign ro_hit   = RO_PAD[idx_tag];
  assign rx_tag   = fifo_read_data[TAG_W+DATA_W-1 -: TAG_W];
  assign rx_data  = fifo_read_data[DATA_W-1:0];

  // A legal read of DATA_IDX clears the interrupt on the edge entering RESP.
  assign irq_clr  = (state == S_DECODE) && !wr && in_range &&
                    (32'(idx) == DATA_IDX);

  // APB transfer FSM
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      wr              <= 1'b0;
      wdata           <= '0;
      pready          <= 1'b0;
      pslverr         <= 1'b0;
      prdata          <= '0;
      fifo_write_inc  <= 1'b0;
      fifo_write_data <= '0;
`ifdef APB_FIFO_BRIDGE_TIMEOUT_EN
      wait_cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (psel && !penable) begin
            idx   <= paddr - BASE_ADDR;
            wr    <= pwrite;
            wdata <= pwdata;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (!in_range || (wr && ro_hit)) begin
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
            state   <= S_RESP;
          end else if (!wr) begin
            // Non-blocking read: an RX update on this same edge is not seen.
            pready <= 1'b1;
            prdata <= shadow[idx_tag];
            state  <= S_RESP;
          end else if (!fifo_write_full) begin
            pready          <= 1'b1;
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {idx_tag, wdata};
            state           <= S_RESP;
          end else begin
`ifdef APB_FIFO_BRIDGE_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
          end else if (!fifo_write_full) begin
            pready          <= 1'b1;
            fifo_write_inc  <= 1'b1;
            fifo_write_data <= {idx_tag, wdata};
            state           <= S_RESP;
`ifdef APB_FIFO_BRIDGE_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            pready  <= 1'b1;
            pslverr <= 1'b1;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end

        S_RESP: begin
          pready         <= 1'b0;
          pslverr        <= 1'b0;
          fifo_write_inc <= 1'b0;
          state          <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // RX drain: pop whenever data is present and the previous pop strobe has
  // retired, giving the FIFO a cycle to present the next head word.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      fifo_read_inc <= 1'b0;
      rx_drop       <= 1'b0;
      irq_rx        <= 1'b0;
      for (int i = 0; i < NSLOT; i++) shadow[i] <= '0;
    end else begin
      fifo_read_inc <= 1'b0;
      rx_drop       <= 1'b0;
      if (irq_clr) irq_rx <= 1'b0;
      if (!fifo_read_empty && !fifo_read_inc) begin
        fifo_read_inc <= 1'b1;
        if (32'(rx_tag) < NUM_REGS) begin
          shadow[rx_tag] <= rx_data;
          // Placed after the clear so a simultaneous set wins.
          if (32'(rx_tag) == DATA_IDX) irq_rx <= 1'b1;
        end else begin
          rx_drop <= 1'b1;
        end
      end
    end
  end

endmodule
